// File: rtl/uart_pkg.sv
// Shared definitions for the buffered UART receiver: FSM encoding, oversampling constants, FIFO sizing.
// Pure declarations; no latency or flow-control behaviour of its own.
// No backpressure; consumers size their logic from these values.
package uart_pkg;

    localparam int OVERSAMPLE = 16;
    localparam int MID_SAMPLE = 8;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_START,
        ST_DATA,
        ST_PARITY,
        ST_STOP,
        ST_WAIT_IDLE
    } rx_state_t;

    function automatic int fifo_addr_w(input int depth);
        return (depth > 1) ? $clog2(depth) : 1;
    endfunction

endpackage

// File: rtl/rx_fifo_fwft.sv
// First-word-fall-through byte FIFO with registered occupancy flags.
// Latency: a pushed byte is at head_dat, with present set, the cycle after the push edge.
// Backpressure: push while full is dropped unless a pop in the same cycle frees a slot; pop while empty is ignored.
module rx_fifo_fwft
    import uart_pkg::*;
#(
    parameter int DEPTH = 16,
    localparam int AW = fifo_addr_w(DEPTH)
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       push,
    input  logic [7:0] push_dat,
    input  logic       pop,
    output logic [7:0] head_dat,
    output logic       present,
    output logic       half_full,
    output logic       full
);

    logic [7:0]    mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [AW:0]   count;
    logic [AW:0]   count_n;
    logic          do_push;
    logic          do_pop;

    assign do_pop  = pop && (count != '0);
    // A same-cycle pop makes room, so a full FIFO still accepts the write.
    assign do_push = push && ((count != (AW+1)'(DEPTH)) || do_pop);
    assign count_n = count + (AW+1)'(do_push) - (AW+1)'(do_pop);

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            count     <= '0;
            present   <= 1'b0;
            half_full <= 1'b0;
            full      <= 1'b0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            count     <= count_n;
            present   <= (count_n != '0);
            half_full <= (count_n >= (AW+1)'(DEPTH / 2));
            full      <= (count_n == (AW+1)'(DEPTH));
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= push_dat;
    end

    assign head_dat = present ? mem[rd_ptr] : 8'h00;

endmodule

// File: rtl/uart_rx_buffered.sv
// Buffered 8N1 RS-232 receiver (16x oversampled) feeding a FWFT FIFO; UART_RX_PARITY_EN adds an even-parity bit.
// Latency: byte readable the cycle after the stop-bit sample (~2 clk + 9.5 bit periods from the start edge).
// Backpressure: none on the line; a byte arriving while the FIFO is full is dropped and overrun_error pulses.
module uart_rx_buffered
    import uart_pkg::*;
#(
    parameter int CLKS_PER_TICK = 27,
    parameter int FIFO_DEPTH    = 16
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       rs232_rx,
    input  logic       read_buffer,
    output logic [7:0] data_out,
    output logic       buffer_data_present,
    output logic       buffer_half_full,
    output logic       buffer_full,
    output logic       framing_error,
    output logic       overrun_error,
    output logic       parity_error
);

    localparam int TW = $clog2(CLKS_PER_TICK);
    localparam logic [3:0] LAST_TICK = 4'(OVERSAMPLE - 1);

    logic          rx_meta;
    logic          rx_sync;
    logic [TW-1:0] div_cnt;
    logic          tick;

    rx_state_t  state, state_n;
    logic [3:0] tick_cnt, tick_cnt_n;
    logic [2:0] bit_idx, bit_idx_n;
    logic [7:0] shift, shift_n;
    logic       push;
    logic       ferr_n;

    always_ff @(posedge clk) begin
        if (reset) begin
            rx_meta <= 1'b1;
            rx_sync <= 1'b1;
        end else begin
            rx_meta <= rs232_rx;
            rx_sync <= rx_meta;
        end
    end

    assign tick = (div_cnt == TW'(CLKS_PER_TICK - 1));

    always_ff @(posedge clk) begin
        if (reset || tick) div_cnt <= '0;
        else               div_cnt <= div_cnt + 1'b1;
    end

`ifdef UART_RX_PARITY_EN
    logic par_bad, par_bad_n;
    logic perr_n;
`endif

    always_comb begin
        state_n    = state;
        tick_cnt_n = tick_cnt;
        bit_idx_n  = bit_idx;
        shift_n    = shift;
        push       = 1'b0;
        ferr_n     = 1'b0;
`ifdef UART_RX_PARITY_EN
        par_bad_n  = par_bad;
        perr_n     = 1'b0;
`endif
        case (state)
            ST_IDLE: begin
                if (tick && !rx_sync) begin
                    state_n    = ST_START;
                    tick_cnt_n = '0;
                    bit_idx_n  = '0;
`ifdef UART_RX_PARITY_EN
                    par_bad_n  = 1'b0;
`endif
                end
            end
            ST_START: begin
                if (tick) begin
                    if (tick_cnt == 4'(MID_SAMPLE - 1)) begin
                        state_n    = rx_sync ? ST_IDLE : ST_DATA;
                        tick_cnt_n = '0;
                        bit_idx_n  = '0;
                    end else begin
                        tick_cnt_n = tick_cnt + 4'd1;
                    end
                end
            end
            ST_DATA: begin
                if (tick) begin
                    tick_cnt_n = tick_cnt + 4'd1;
                    if (tick_cnt == LAST_TICK) begin
                        shift_n   = {rx_sync, shift[7:1]};
                        bit_idx_n = bit_idx + 3'd1;
                        if (bit_idx == 3'd7) begin
`ifdef UART_RX_PARITY_EN
                            state_n = ST_PARITY;
`else
                            state_n = ST_STOP;
`endif
                            tick_cnt_n = '0;
                            bit_idx_n  = '0;
                        end
                    end
                end
            end
`ifdef UART_RX_PARITY_EN
            ST_PARITY: begin
                if (tick) begin
                    tick_cnt_n = tick_cnt + 4'd1;
                    if (tick_cnt == LAST_TICK) begin
                        par_bad_n  = ((^shift) != rx_sync);
                        state_n    = ST_STOP;
                        tick_cnt_n = '0;
                    end
                end
            end
`endif
            ST_STOP: begin
                if (tick) begin
                    tick_cnt_n = tick_cnt + 4'd1;
                    if (tick_cnt == LAST_TICK) begin
                        tick_cnt_n = '0;
                        if (!rx_sync) begin
                            // Line still low: treat as break and wait for idle before re-arming.
                            ferr_n  = 1'b1;
                            state_n = ST_WAIT_IDLE;
`ifdef UART_RX_PARITY_EN
                            perr_n  = par_bad;
`endif
                        end else begin
                            state_n = ST_IDLE;
`ifdef UART_RX_PARITY_EN
                            if (par_bad) perr_n = 1'b1;
                            else         push   = 1'b1;
`else
                            push = 1'b1;
`endif
                        end
                    end
                end
            end
            ST_WAIT_IDLE: begin
                if (tick && rx_sync) begin
                    state_n    = ST_IDLE;
                    tick_cnt_n = '0;
                    bit_idx_n  = '0;
                end
            end
            default: state_n = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state         <= ST_IDLE;
            tick_cnt      <= '0;
            bit_idx       <= '0;
            shift         <= '0;
            framing_error <= 1'b0;
            overrun_error <= 1'b0;
        end else begin
            state         <= state_n;
            tick_cnt      <= tick_cnt_n;
            bit_idx       <= bit_idx_n;
            shift         <= shift_n;
            framing_error <= ferr_n;
            overrun_error <= push && buffer_full && !read_buffer;
        end
    end

`ifdef UART_RX_PARITY_EN
    always_ff @(posedge clk) begin
        if (reset) begin
            par_bad      <= 1'b0;
            parity_error <= 1'b0;
        end else begin
            par_bad      <= par_bad_n;
            parity_error <= perr_n;
        end
    end
`else
    assign parity_error = 1'b0;
`endif

    rx_fifo_fwft #(.DEPTH(FIFO_DEPTH)) u_fifo (
        .clk       (clk),
        .reset     (reset),
        .push      (push),
        .push_dat  (shift),
        .pop       (read_buffer),
        .head_dat  (data_out),
        .present   (buffer_data_present),
        .half_full (buffer_half_full),
        .full      (buffer_full)
    );

endmodule

// File: tb/tb_uart_rx_buffered.sv
// Scoreboard bench for uart_rx_buffered: frames are modelled as a byte queue plus expected error events.
module tb_uart_rx_buffered;

    localparam int CPT   = 4;
    localparam int DEPTH = 4;
    localparam int BIT   = CPT * 16;
    localparam int FERR  = 1;
    localparam int OVR   = 2;
    localparam int PERR  = 3;
`ifdef UART_RX_PARITY_EN
    localparam bit PAR_EN = 1'b1;
`else
    localparam bit PAR_EN = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       reset;
    logic       rs232_rx;
    logic       read_buffer;
    logic [7:0] data_out;
    logic       buffer_data_present;
    logic       buffer_half_full;
    logic       buffer_full;
    logic       framing_error;
    logic       overrun_error;
    logic       parity_error;

    int         n_checks = 0;
    int         n_pass   = 0;
    int         cyc      = 0;
    logic [7:0] model_q[$];
    int         exp_err[$];
    bit         sim_read = 1'b0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    uart_rx_buffered #(.CLKS_PER_TICK(CPT), .FIFO_DEPTH(DEPTH)) dut (
        .clk                 (clk),
        .reset               (reset),
        .rs232_rx            (rs232_rx),
        .read_buffer         (read_buffer),
        .data_out            (data_out),
        .buffer_data_present (buffer_data_present),
        .buffer_half_full    (buffer_half_full),
        .buffer_full         (buffer_full),
        .framing_error       (framing_error),
        .overrun_error       (overrun_error),
        .parity_error        (parity_error)
    );

    task automatic chk(input string name, input int act, input int exp);
        n_checks++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    endtask

    task automatic err_event(input string name, input int code);
        int e;
        e = (exp_err.size() != 0) ? exp_err[0] : 0;
        chk(name, code, e);
        if (exp_err.size() != 0) void'(exp_err.pop_front());
    endtask

    task automatic check_flags(input string name);
        int sz;
        sz = model_q.size();
        chk({name, "_present"}, int'(buffer_data_present), int'(sz != 0));
        chk({name, "_half"}, int'(buffer_half_full), int'(sz >= DEPTH / 2));
        chk({name, "_full"}, int'(buffer_full), int'(sz >= DEPTH));
        chk({name, "_data"}, int'(data_out), (sz != 0) ? int'(model_q[0]) : 0);
    endtask

    task automatic check_drained(input string name);
        chk(name, exp_err.size(), 0);
    endtask

    // Reference behaviour of one complete frame, decided before its stop bit is on the line.
    task automatic model_frame(input logic [7:0] b, input logic stop_ok, input logic par_ok);
        if (!stop_ok) begin
            exp_err.push_back(FERR);
            if (!par_ok) exp_err.push_back(PERR);
        end else if (!par_ok) begin
            exp_err.push_back(PERR);
        end else if (model_q.size() >= DEPTH && !sim_read) begin
            exp_err.push_back(OVR);
        end else begin
            model_q.push_back(b);
        end
    endtask

    task automatic drive_bits(input logic v, input int n);
        rs232_rx = v;
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic send_frame(input logic [7:0] b, input logic stop_ok, input int stop_len, input logic par_ok);
        drive_bits(1'b0, BIT);
        for (int i = 0; i < 8; i++) drive_bits(b[i], BIT);
        if (PAR_EN) drive_bits(par_ok ? ^b : ~(^b), BIT);
        model_frame(b, stop_ok, par_ok);
        drive_bits(stop_ok, BIT * stop_len);
        drive_bits(1'b1, BIT * 2);
    endtask

    task automatic do_read();
        read_buffer = 1'b1;
        idle(1);
        read_buffer = 1'b0;
        idle(1);
    endtask

    always @(negedge clk) begin
        if (!reset) begin
            if (read_buffer) begin
                chk("rd_present", int'(buffer_data_present), int'(model_q.size() != 0));
                if (model_q.size() != 0) begin
                    chk("rd_data", int'(data_out), int'(model_q[0]));
                    void'(model_q.pop_front());
                end else begin
                    chk("rd_empty_data", int'(data_out), 0);
                end
            end
            if (framing_error) err_event("framing_error", FERR);
            if (overrun_error) err_event("overrun_error", OVR);
            if (parity_error)  err_event("parity_error", PERR);
        end
    end

    initial begin : main
        int lat, t0, cal0, nr;
        logic [7:0] b;
        logic s_ok, p_ok;

        reset = 1'b1;
        rs232_rx = 1'b1;
        read_buffer = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        reset = 1'b0;
        @(negedge clk);
        check_flags("reset");
        chk("reset_ferr", int'(framing_error), 0);
        chk("reset_ovr", int'(overrun_error), 0);
        chk("reset_perr", int'(parity_error), 0);
        idle(1);

        // Single byte, with write latency measured from the start edge.
        lat = -1;
        t0 = cyc;
        cal0 = t0;
        fork
            send_frame(8'hA5, 1'b1, 1, 1'b1);
            begin
                for (int i = 0; i < 2000 && lat < 0; i++) begin
                    @(negedge clk);
                    if (buffer_data_present) lat = cyc - t0;
                end
            end
        join
        chk("a5_latency_window", int'(lat >= 600 && lat <= 620), 1);
        if (lat < 0) lat = 610;
        check_flags("a5_stored");
        do_read();
        check_flags("a5_after_read");

        // Short low glitch on an idle line.
        rs232_rx = 1'b0;
        idle(16);
        rs232_rx = 1'b1;
        idle(BIT * 2);
        check_flags("glitch");
        check_drained("glitch_no_err");

        // Stop bit held low, then a clean frame.
        send_frame(8'h3C, 1'b0, 3, 1'b1);
        check_drained("ferr_seen");
        check_flags("ferr_fifo");
        send_frame(8'h81, 1'b1, 1, 1'b1);
        check_flags("after_81");
        do_read();

        // Fill past capacity.
        for (int k = 1; k <= 5; k++) begin
            send_frame(8'(k), 1'b1, 1, 1'b1);
            check_flags($sformatf("fill%0d", k));
        end
        check_drained("overrun_seen");

        // Read strobe lands exactly on the write edge of a new byte while full.
        while (((cyc - cal0) % CPT) != 0) idle(1);
        t0 = cyc;
        sim_read = 1'b1;
        fork
            send_frame(8'h06, 1'b1, 1, 1'b1);
            begin
                while (cyc < t0 + lat - 1) idle(1);
                read_buffer = 1'b1;
                idle(1);
                read_buffer = 1'b0;
            end
        join
        sim_read = 1'b0;
        check_flags("sim_rw");
        check_drained("sim_no_overrun");
        for (int i = 0; i < DEPTH + 1 && model_q.size() != 0; i++) do_read();
        check_flags("sim_drained");

`ifdef UART_RX_PARITY_EN
        send_frame(8'h07, 1'b1, 1, 1'b0);
        check_flags("par_bad");
        send_frame(8'h07, 1'b1, 1, 1'b1);
        check_flags("par_good");
        send_frame(8'h07, 1'b0, 1, 1'b0);
        check_drained("par_and_ferr");
        do_read();
`endif

        // Randomised traffic.
        for (int k = 0; k < 12; k++) begin
            b = 8'($urandom);
            s_ok = ($urandom_range(0, 5) != 0);
            p_ok = PAR_EN ? ($urandom_range(0, 3) != 0) : 1'b1;
            send_frame(b, s_ok, 1, p_ok);
            check_flags($sformatf("rand%0d", k));
            nr = $urandom_range(0, 2);
            repeat (nr) do_read();
        end
        check_drained("rand_errs");
        for (int i = 0; i < DEPTH + 1 && model_q.size() != 0; i++) do_read();

        // Reset in the middle of a frame with a byte already buffered.
        send_frame(8'h5A, 1'b1, 1, 1'b1);
        check_flags("pre_reset");
        drive_bits(1'b0, BIT);
        drive_bits(1'b1, BIT);
        drive_bits(1'b0, BIT / 2);
        reset = 1'b1;
        @(posedge clk);
        @(negedge clk);
        model_q.delete();
        check_flags("mid_reset");
        chk("mid_reset_ferr", int'(framing_error), 0);
        chk("mid_reset_ovr", int'(overrun_error), 0);
        chk("mid_reset_perr", int'(parity_error), 0);
        @(posedge clk);
        #1;
        reset = 1'b0;
        rs232_rx = 1'b1;
        idle(BIT * 2);
        check_flags("post_reset_idle");
        send_frame(8'hC3, 1'b1, 1, 1'b1);
        check_flags("post_reset_byte");
        do_read();
        check_drained("final_errs");

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #2000000;
        n_checks++;
        $display("FAIL watchdog: got timeout, expected completion");
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/uart_rx_buffered.md
# uart_rx_buffered

Buffered RS-232 receiver that feeds the PicoBlaze loopback system. Takes the asynchronous `rs232_rx` line, recovers 8N1 frames with 16× oversampling, and stores received bytes in a first-word-fall-through FIFO. The PicoBlaze reads the FIFO through an input port with a one-cycle read strobe. Status flags for empty, half-full, full, framing, overrun and (optionally) parity are brought out for polling.

## Interface
- `CLKS_PER_TICK`, default 27: clk cycles per 1/16 bit period (50 MHz, 115200 baud). Must be ≥ 2.
- `FIFO_DEPTH`, default 16: FIFO entries. Must be a power of 2, ≥ 4.
- `clk`  in  1: single clock; all logic is rising-edge.
- `reset`  in  1: synchronous, active-high.
- `rs232_rx`  in  1: asynchronous serial line, idle high.
- `read_buffer`  in  1: pop strobe, one cycle per byte.
- `data_out`  out  8: oldest FIFO byte; 8'h00 while the FIFO is empty.
- `buffer_data_present`  out  1: FIFO count ≠ 0.
- `buffer_half_full`  out  1: FIFO count ≥ FIFO_DEPTH/2.
- `buffer_full`  out  1: FIFO count == FIFO_DEPTH.
- `framing_error`  out  1: one-cycle pulse.
- `overrun_error`  out  1: one-cycle pulse.
- `parity_error`  out  1: one-cycle pulse; tied 0 when parity is compiled out.

## Operation
- `rs232_rx` passes through a 2-flop synchronizer. Both flops reset to 1.
- Tick generator:
  - Counter 0..CLKS_PER_TICK-1; `tick` is high for one cycle at terminal count.
  - The counter is free-running and is reset only by `reset`.
- Receiver FSM states: IDLE, START, DATA, [PARITY], STOP, WAIT_IDLE. A tick counter (0..15) and a bit index (0..7) are cleared on each state entry.
- IDLE: when synced rx = 0 is sampled on a tick → START.
- START: at the 8th tick, sample rx.
  - rx = 1: false start → IDLE, nothing written.
  - rx = 0: → DATA.
- DATA: sample every 16 ticks, shifting LSB first. After bit 7 → PARITY if compiled in, else STOP.
- STOP: at the 16th tick, sample rx.
  - rx = 1, no pending parity fault: write the byte to the FIFO → IDLE.
  - rx = 0: pulse `framing_error`, discard the byte → WAIT_IDLE.
- WAIT_IDLE: stay until rx = 1 is sampled on a tick → IDLE. This blocks re-triggering on a break condition.
- FIFO write when `buffer_full`: byte dropped, `overrun_error` pulses, FIFO unchanged.
- FIFO read:
  - `read_buffer` with count > 0 pops; `data_out` shows the next byte on the following cycle.
  - `read_buffer` when empty is ignored.
- Simultaneous write and read, count > 0: both occur, count unchanged. With count == 0 the read is ignored and the write occurs.
- Simultaneous write and read when full: the read frees a slot, so the write is accepted and there is no overrun.
- Read and write pointers wrap modulo FIFO_DEPTH. Count is kept in log2(FIFO_DEPTH)+1 bits.
- Reset mid-frame: FSM → IDLE, FIFO emptied, shift register cleared. The partial frame is lost.

## Timing
- Reset values: `data_out` 8'h00; all flags 0; FSM IDLE; count 0.
- A byte is visible: `buffer_data_present` = 1 and `data_out` valid in the cycle after the stop-bit sample edge.
- Frame latency from the rx falling edge ≈ 2 clk (sync) + 9.5 bit periods ± 1 tick.
- Error pulses last exactly one clk, in the cycle after the offending sample.
- Flags are registered and update the cycle after the push or pop that changes the count.

## Configuration
- Macro: `UART_RX_PARITY_EN`.
- Defined:
  - A PARITY state follows DATA and samples one even-parity bit 16 ticks after D7.
  - On mismatch, `parity_error` pulses at the STOP sample and the byte is discarded. A framing error takes precedence and both pulse if both occur.
- Undefined:
  - No PARITY state; frames are 8N1.
  - `parity_error` is a constant 0.

## Structure
- Shared package `uart_pkg`:
  - FSM state encoding.
  - Constants OVERSAMPLE = 16 and MID_SAMPLE = 8.
  - Helper to compute FIFO address width from FIFO_DEPTH.
- Sub-module `rx_fifo_fwft`: synchronous FWFT FIFO with push, pop, count and flags. The receiver FSM, synchronizer and tick generator stay in the top module.

## Test plan
All scenarios use CLKS_PER_TICK = 4 and FIFO_DEPTH = 4 for simulation speed, so 1 bit = 64 clk.
- Send 8'hA5 as 8N1 → `buffer_data_present` rises about 610 clk after the start edge; `data_out` = 8'hA5; `read_buffer` pulse → present = 0, `data_out` = 8'h00.
- Send a 16 clk low glitch on idle rx → no write, no error pulses, FSM returns to IDLE.
- Send 8'h3C with the stop bit held low for 3 bit times → one `framing_error` pulse, FIFO empty, next 8'h81 received correctly after rx returns high.
- Send 5 bytes 8'h01..8'h05 with no reads:
  - `buffer_half_full` sets after the 2nd byte and `buffer_full` after the 4th.
  - The 5th byte causes an `overrun_error` pulse.
  - Reads return 01, 02, 03, 04.
- Full FIFO with `read_buffer` asserted exactly in the write cycle of a new byte → no overrun, count stays 4, order preserved.
- Under `UART_RX_PARITY_EN`: 8'h07 with parity bit 0 (wrong) → `parity_error` pulse, FIFO empty; 8'h07 with parity bit 1 → accepted. `reset` asserted mid-frame → all outputs at reset values the next cycle.
